lsosc_clkdiv: RTL and testbench
===============================

LSOSC_CLKDIV -- requirements
Module: lsosc_clkdiv

Interface
REQ-001 Parameter WARMUP, default 16: number of CLKK cycles spent in WARM before the divided output starts.
REQ-002 Parameter DIVW, default 8: width of the divisor field.
REQ-003 Parameter DIV_RST, default 0: divisor register value after reset.
REQ-004 The block SHALL have exactly one clock; reset is synchronous and active-high.
REQ-005 CLKK  in  1: low-speed oscillator clock; all logic is rising-edge CLKK.
REQ-006 RST  in  1: synchronous active-high reset.
REQ-007 EN  in  1: divider run request.
REQ-008 DIV_LD  in  1: one-cycle request to load DIV_VAL.
REQ-009 DIV_VAL  in  DIVW: requested half-period minus one.
REQ-010 DIV_ACK  out  1: one-cycle pulse when a loaded value takes effect.
REQ-011 CLKDIV  out  1: registered divided clock with 50% duty cycle.
REQ-012 TICK  out  1: one-cycle pulse in the first cycle of each CLKDIV high phase.
REQ-013 LOCK  out  1: high while in RUN.

Function
REQ-014 The FSM SHALL have states IDLE, WARM and RUN.
- IDLE to WARM when EN=1.
- WARM to RUN after exactly WARMUP cycles in WARM.
- WARM to IDLE when EN=0.
REQ-015 In WARM, a warm-up counter SHALL count 0..WARMUP-1.
- RUN is entered on the edge after the cycle with count WARMUP-1.
- The counter SHALL clear on every entry to WARM.
REQ-016 LOCK SHALL be 1 exactly when the state is RUN.
REQ-017 In IDLE and WARM:
- CLKDIV=0, TICK=0.
- The half-period counter hc is held at 0.
REQ-018 In RUN, hc SHALL count 0..DIVR; when hc==DIVR, hc wraps to 0 and CLKDIV toggles on that edge.
REQ-019 CLKDIV period SHALL be 2*(DIVR+1) CLKK cycles. DIVR=0 gives a period of 2; DIVR=2^DIVW-1 gives a period of 2^(DIVW+1); no overflow is permitted.
REQ-020 On the first RUN cycle, CLKDIV=0 and hc=0; the first rising edge of CLKDIV SHALL occur DIVR+1 cycles after RUN entry.
REQ-021 TICK SHALL be high in exactly the cycles where CLKDIV is 1 and was 0 in the previous cycle.
REQ-022 Period boundary: the cycle in RUN with CLKDIV=1 and hc==DIVR, i.e. the edge on which CLKDIV falls.
REQ-023 Divisor loads in RUN:
- DIV_LD=1 SHALL capture DIV_VAL into a pending register and set a pending flag.
- DIVR updates only at the next period boundary.
- The new value governs the low phase that follows, so no runt pulse is produced.
REQ-024 Divisor loads in IDLE or WARM: DIV_LD=1 SHALL write DIVR directly on that edge.
REQ-025 DIV_ACK SHALL pulse high for one cycle in the cycle after DIVR changes due to a load.
REQ-026 Repeated loads:
- A DIV_LD while a value is pending SHALL overwrite the pending value (last write wins).
- Only one DIV_ACK is issued, for the value actually applied.
REQ-027 Load coinciding with a boundary: DIV_LD in the same cycle as a period boundary SHALL be applied at that boundary.
REQ-028 Glitch-free stop:
- EN=0 in RUN SHALL NOT truncate a phase.
- The FSM leaves RUN for IDLE at the next period boundary, so CLKDIV ends low after a full high phase.
- If EN returns to 1 before that boundary, RUN continues uninterrupted.
REQ-029 A pending load still outstanding on a stop SHALL be applied at the same boundary, with DIV_ACK issued.

Reset
REQ-030 When RST=1 on a rising CLKK edge, the block SHALL reset to:
- state=IDLE, warm-up counter=0, hc=0.
- DIVR=DIV_RST, pending flag cleared.
- CLKDIV=0, TICK=0, DIV_ACK=0, LOCK=0.
REQ-031 RST SHALL take priority over EN and DIV_LD in the same cycle.
REQ-032 RST mid-RUN SHALL force CLKDIV low on that edge; a short final high phase is accepted.
REQ-033 While RST=1, outputs SHALL hold their reset values; after release, operation restarts from IDLE.

Verification
REQ-034 Start-up: WARMUP=16, DIV_RST=0, EN=1 from reset release.
- LOCK rises 16 cycles after entering WARM.
- CLKDIV toggles every cycle.
- TICK is high on every second cycle.
REQ-035 Runtime reload: DIVR=3 in RUN, DIV_LD with DIV_VAL=1 mid-high-phase.
- Current high phase stays 4 cycles.
- Next low phase is 2 cycles.
- DIV_ACK is a single pulse one cycle after the boundary.
REQ-036 Double load: DIV_LD with 5, then with 7 before the boundary.
- DIVR=7 at the boundary.
- Exactly one DIV_ACK.
- Subsequent period is 16.
REQ-037 Stop: DIVR=2, EN=0 one cycle into the high phase.
- High phase completes its full 3 cycles.
- CLKDIV falls and LOCK=0 on the same edge.
- Next state is IDLE.
REQ-038 Abort warm-up: EN=0 at warm-up count 5.
- IDLE on the next cycle.
- Re-asserting EN restarts the count from 0 and gives a full 16-cycle warm-up.
REQ-039 Reset in RUN: RST during a CLKDIV high phase.
- All outputs are 0 on the next cycle.
- DIVR=DIV_RST.
- Pending flag is cleared and no DIV_ACK is issued.

Source files
------------

// File: rtl/lsosc_clkdiv.sv
// lsosc_clkdiv: warm-up sequenced 50%-duty clock divider with
// boundary-aligned divisor reload and glitch-free stop.
module lsosc_clkdiv #(
    parameter int              WARMUP  = 16,
    parameter int              DIVW    = 8,
    parameter logic [DIVW-1:0] DIV_RST = '0
) (
    input  logic            clkk_i,
    input  logic            rst_i,
    input  logic            en_i,
    input  logic            div_ld_i,
    input  logic [DIVW-1:0] div_val_i,
    output logic            div_ack_o,
    output logic            clkdiv_o,
    output logic            tick_o,
    output logic            lock_o
);
    localparam int WW = $clog2(WARMUP + 1);
    typedef enum logic [1:0] {IDLE, WARM, RUN} state_t;
    state_t state_q, state_d;
    logic [WW-1:0] wcnt_q, wcnt_d;
    logic [DIVW-1:0] hc_q, hc_d, divr_q, divr_d, pval_q, pval_d;
    logic pend_q, pend_d, clk_q, clk_d, tick_q, tick_d, ack_q, ack_d;
    logic run, wrap, bnd, wdone, apply;
    always_comb begin
        run = state_q == RUN;
        wrap = run && hc_q == divr_q;
        bnd = wrap && clk_q;
        wdone = wcnt_q == WW'(WARMUP - 1);
        // In RUN a new divisor only lands on the falling edge, so phases are never cut short
        apply = run ? bnd && (div_ld_i || pend_q) : div_ld_i;
        state_d = state_q == IDLE ? (en_i ? WARM : IDLE)
                : state_q == WARM ? (!en_i ? IDLE : wdone ? RUN : WARM)
                : (bnd && !en_i ? IDLE : RUN);
        wcnt_d = (state_q == WARM && en_i && !wdone) ? wcnt_q + 1'b1 : '0;
        hc_d = (run && !wrap) ? hc_q + 1'b1 : '0;
        clk_d = run && (clk_q ^ wrap);
        divr_d = apply ? (div_ld_i ? div_val_i : pval_q) : divr_q;
        pend_d = run && !bnd && (pend_q || div_ld_i);
        pval_d = (run && !bnd && div_ld_i) ? div_val_i : pval_q;
        ack_d = apply;
        tick_d = clk_d && !clk_q;
    end
    always_ff @(posedge clkk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            wcnt_q <= '0;
            hc_q <= '0;
            divr_q <= DIV_RST;
            pval_q <= '0;
            pend_q <= 1'b0;
            clk_q <= 1'b0;
            tick_q <= 1'b0;
            ack_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q <= wcnt_d;
            hc_q <= hc_d;
            divr_q <= divr_d;
            pval_q <= pval_d;
            pend_q <= pend_d;
            clk_q <= clk_d;
            tick_q <= tick_d;
            ack_q <= ack_d;
        end
    end
    assign div_ack_o = ack_q;
    assign clkdiv_o = clk_q;
    assign tick_o = tick_q;
    assign lock_o = state_q == RUN;
endmodule

// File: tb/tb_lsosc_clkdiv.sv
// tb_lsosc_clkdiv: directed and random checks of lsosc_clkdiv against a
// phase-length reference model.
module tb_lsosc_clkdiv;
    localparam int WARMUP = 16;
    localparam int DIVW = 8;
    logic clk = 1'b0;
    logic rst, en, ld;
    logic [DIVW-1:0] val;
    logic ack, cdiv, tick, lock;
    int ncmp = 0, nerr = 0, acks = 0;
    int m_mode, m_wleft, m_left, m_divr, m_pval;
    bit m_lvl, m_pend, m_ack, m_tick;

    always #5 clk = ~clk;

    lsosc_clkdiv #(.WARMUP(WARMUP), .DIVW(DIVW), .DIV_RST(8'd0)) dut (
        .clkk_i(clk), .rst_i(rst), .en_i(en), .div_ld_i(ld), .div_val_i(val),
        .div_ack_o(ack), .clkdiv_o(cdiv), .tick_o(tick), .lock_o(lock)
    );

    task automatic check(input string tag, input logic [31:0] got, input int exp);
        ncmp++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Model: mode 0 idle, 1 warm, 2 run; m_left = cycles left in current phase
    task automatic model(input bit r, input bit e, input bit l, input int v);
        bit nack, ntick;
        nack = 0;
        ntick = 0;
        if (r) begin
            m_mode = 0; m_lvl = 0; m_divr = 0; m_pend = 0; m_left = 0; m_wleft = 0;
        end else if (m_mode != 2) begin
            if (l) begin m_divr = v; nack = 1; end
            if (m_mode == 0) begin
                if (e) begin m_mode = 1; m_wleft = WARMUP; end
            end else if (!e) m_mode = 0;
            else begin
                m_wleft--;
                if (m_wleft == 0) begin m_mode = 2; m_lvl = 0; m_left = m_divr + 1; end
            end
        end else if (m_left == 1 && m_lvl) begin
            if (l || m_pend) begin m_divr = l ? v : m_pval; nack = 1; end
            m_pend = 0;
            m_lvl = 0;
            m_left = m_divr + 1;
            if (!e) m_mode = 0;
        end else begin
            if (l) begin m_pend = 1; m_pval = v; end
            if (m_left == 1) begin m_lvl = 1; ntick = 1; m_left = m_divr + 1; end
            else m_left--;
        end
        m_ack = nack;
        m_tick = ntick;
    endtask

    task automatic step(input bit r, input bit e, input bit l, input int v);
        rst = r; en = e; ld = l; val = v[DIVW-1:0];
        @(posedge clk);
        model(r, e, l, v);
        #1;
        if (ack === 1'b1) acks++;
        check("clkdiv", cdiv, int'(m_lvl));
        check("tick", tick, int'(m_tick));
        check("lock", lock, int'(m_mode == 2));
        check("div_ack", ack, int'(m_ack));
    endtask

    task automatic run_until_tick(input string tag);
        int n;
        n = 0;
        do begin step(0, 1, 0, 0); n++; end while (tick !== 1'b1 && n < 2000);
        check({tag, "_tick_timeout"}, tick, 1);
    endtask

    initial begin
        int n;
        bit r, e, l;
        int v;
        rst = 1; en = 0; ld = 0; val = '0;
        step(1, 0, 0, 0);
        step(1, 1, 1, 9);
        check("reset_div_ack", ack, 0);
        // start-up with DIVR=0
        for (int i = 0; i < WARMUP; i++) step(0, 1, 0, 0);
        check("lock_before_warmup_end", lock, 0);
        step(0, 1, 0, 0);
        check("lock_after_warmup", lock, 1);
        check("first_run_cycle_low", cdiv, 0);
        step(0, 1, 0, 0);
        check("div0_first_rise", cdiv, 1);
        for (int i = 0; i < 10; i++) step(0, 1, 0, 0);
        // runtime reload: DIVR=3, then load 1 mid-high-phase
        step(0, 1, 1, 3);
        run_until_tick("r3a");
        run_until_tick("r3b");
        step(0, 1, 0, 0);
        acks = 0;
        step(0, 1, 1, 1);
        for (int i = 0; i < 20; i++) step(0, 1, 0, 0);
        check("reload_single_ack", acks, 1);
        // double load: 5 then 7, last write wins
        run_until_tick("dl");
        acks = 0;
        step(0, 1, 1, 5);
        step(0, 1, 1, 7);
        for (int i = 0; i < 40; i++) step(0, 1, 0, 0);
        check("double_load_single_ack", acks, 1);
        run_until_tick("p16");
        n = 0;
        do begin step(0, 1, 0, 0); n++; end while (tick !== 1'b1 && n < 100);
        check("period_after_double_load", n, 16);
        // glitch-free stop with DIVR=2
        step(0, 1, 1, 2);
        run_until_tick("st1");
        run_until_tick("st2");
        step(0, 0, 0, 0);
        check("stop_high_continues", cdiv, 1);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0);
        check("stop_lock_low", lock, 0);
        check("stop_clkdiv_low", cdiv, 0);
        // abort warm-up at count 5, then full warm-up
        for (int i = 0; i < 6; i++) step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        check("abort_lock", lock, 0);
        for (int i = 0; i < WARMUP; i++) step(0, 1, 0, 0);
        check("rewarm_lock_before_end", lock, 0);
        step(0, 1, 0, 0);
        check("rewarm_lock_after_end", lock, 1);
        // reset during a high phase with a load pending
        run_until_tick("rr");
        step(0, 1, 1, 9);
        step(1, 1, 1, 4);
        check("rst_run_clkdiv", cdiv, 0);
        check("rst_run_lock", lock, 0);
        step(0, 0, 0, 0);
        check("rst_run_no_ack", ack, 0);
        // random traffic
        for (int i = 0; i < 4000; i++) begin
            r = $urandom_range(0, 499) == 0;
            e = $urandom_range(0, 19) != 0;
            l = $urandom_range(0, 9) == 0;
            v = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 5));
            step(r, e, l, v);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
